// File: rtl/sccb_cfg_sched_pkg.sv
// rtl/sccb_cfg_sched_pkg.sv - shared types and constants for the dual-camera SCCB init scheduler
package sccb_cfg_sched_pkg;

  localparam int          TBL_W      = 24;
  localparam logic [15:0] DELAY_MARK = 16'hFFFF;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_ISSUE,
    ST_BUSY,
    ST_GAP,
    ST_DELAY,
    ST_NEXT,
    ST_DONE
  } state_t;

  // A table entry whose register address is the marker is a pause, not a write
  function automatic logic is_delay_entry(input logic [15:0] reg_addr);
    return reg_addr == DELAY_MARK;
  endfunction

endpackage

// File: rtl/sccb_cfg_sched_if.sv
// rtl/sccb_cfg_sched_if.sv - write-request handshake between the scheduler and the shared SCCB master
interface sccb_cfg_sched_if;

  logic        i2c_req;
  logic [7:0]  i2c_dev;
  logic [15:0] i2c_reg;
  logic [7:0]  i2c_wdata;
  logic        i2c_done;
  logic        i2c_nack;
  logic        cam_sel;

  modport master (
    output i2c_req,
    output i2c_dev,
    output i2c_reg,
    output i2c_wdata,
    output cam_sel,
    input  i2c_done,
    input  i2c_nack
  );

  modport slave (
    input  i2c_req,
    input  i2c_dev,
    input  i2c_reg,
    input  i2c_wdata,
    input  cam_sel,
    output i2c_done,
    output i2c_nack
  );

endinterface

// File: rtl/sccb_cfg_sched_delay_cnt.sv
// rtl/sccb_cfg_sched_delay_cnt.sv - loadable down-counter shared by the inter-transaction gap and table delays
module sccb_cfg_sched_delay_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         last
);

  logic [W-1:0] cnt;

  // Load wins over decrement; the count saturates at zero instead of wrapping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  // Flagging the final cycle (count 1) makes a load of N last exactly N cycles
  assign last = (cnt <= W'(1));

endmodule

// File: rtl/sccb_cfg_sched.sv
// rtl/sccb_cfg_sched.sv - walks the OV5640 init table once, writing each entry to cam0 then cam1
module sccb_cfg_sched
  import sccb_cfg_sched_pkg::*;
#(
  parameter int          REG_NUM    = 250,
  parameter logic [7:0]  DEV_ADDR   = 8'h78,
  parameter int          RETRY_MAX  = 3,
  parameter int          GAP_CYC    = 100,
  parameter int          DELAY_UNIT = 10000,
  localparam int         IW         = (REG_NUM > 1) ? $clog2(REG_NUM) : 1
) (
  input  logic             clk_10M,
  input  logic             rst_n,
  input  logic             initial_en,
  output logic [IW-1:0]    tbl_addr,
  input  logic [TBL_W-1:0] tbl_data,
  sccb_cfg_sched_if.master bus,
  output logic             cmos1_cfg_ok,
  output logic             cmos2_cfg_ok,
  output logic             cmos_init_done,
  output logic [1:0]       cam_fail
);

  // Counter must hold the longest table delay without wrapping
  localparam int CNT_MAX = (255 * DELAY_UNIT > GAP_CYC) ? 255 * DELAY_UNIT : GAP_CYC;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int RW      = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;
  localparam logic [IW-1:0] LAST_ADDR = IW'(REG_NUM - 1);

  state_t        state, state_nxt;
  logic          fetch_ph;
  logic [15:0]   lat_reg;
  logic [7:0]    lat_data;
  logic          cam_sel_q;
  logic          switch_cam;
  logic [RW-1:0] retry;
  logic [1:0]    cam_fail_q;

  logic          cnt_load;
  logic [CW-1:0] cnt_val;
  logic          cnt_dec;
  logic          cnt_last;

  logic          retry_again;
  logic          to_cam1;

  assign retry_again = bus.i2c_nack && (retry < RW'(RETRY_MAX));
  assign to_cam1     = !cam_sel_q && !cam_fail_q[1];

  sccb_cfg_sched_delay_cnt #(
    .W (CW)
  ) u_delay_cnt (
    .clk      (clk_10M),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .last     (cnt_last)
  );

  // State register
  always_ff @(posedge clk_10M or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode and counter control
  always_comb begin
    state_nxt = state;
    cnt_load  = 1'b0;
    cnt_val   = '0;
    cnt_dec   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (initial_en) state_nxt = ST_FETCH;
      end
      ST_FETCH: begin
        if (fetch_ph) state_nxt = ST_DECODE;
      end
      ST_DECODE: begin
        if (is_delay_entry(lat_reg)) begin
          state_nxt = ST_DELAY;
          cnt_load  = 1'b1;
          cnt_val   = CW'(lat_data) * CW'(DELAY_UNIT);
        end else if (lat_data == 8'h00) begin
          state_nxt = ST_NEXT;
        end else if (&cam_fail_q) begin
          state_nxt = ST_NEXT;
        end else begin
          state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        state_nxt = ST_BUSY;
      end
      ST_BUSY: begin
        if (bus.i2c_done) begin
          if (retry_again || to_cam1) begin
            state_nxt = ST_GAP;
            cnt_load  = 1'b1;
            cnt_val   = CW'(GAP_CYC);
          end else begin
            state_nxt = ST_NEXT;
          end
        end
      end
      ST_GAP: begin
        cnt_dec = 1'b1;
        if (cnt_last) state_nxt = ST_ISSUE;
      end
      ST_DELAY: begin
        cnt_dec = 1'b1;
        if (cnt_last) state_nxt = ST_NEXT;
      end
      ST_NEXT: begin
        state_nxt = (tbl_addr == LAST_ADDR) ? ST_DONE : ST_FETCH;
      end
      ST_DONE: begin
        state_nxt = ST_DONE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Entry latch, camera selection, retry bookkeeping and table pointer
  always_ff @(posedge clk_10M or negedge rst_n) begin
    if (!rst_n) begin
      fetch_ph   <= 1'b0;
      lat_reg    <= '0;
      lat_data   <= '0;
      cam_sel_q  <= 1'b0;
      switch_cam <= 1'b0;
      retry      <= '0;
      cam_fail_q <= '0;
      tbl_addr   <= '0;
    end else begin
      case (state)
        ST_FETCH: begin
          fetch_ph <= ~fetch_ph;
          if (fetch_ph) begin
            lat_reg   <= tbl_data[23:8];
            lat_data  <= tbl_data[7:0];
            // Selecting the camera while entering DECODE keeps it clear of the req edge
            cam_sel_q <= cam_fail_q[0];
          end
        end
        ST_BUSY: begin
          if (bus.i2c_done) begin
            if (retry_again) begin
              retry <= retry + 1'b1;
            end else begin
              retry <= '0;
              if (bus.i2c_nack) cam_fail_q[cam_sel_q] <= 1'b1;
              if (to_cam1) switch_cam <= 1'b1;
            end
          end
        end
        ST_GAP: begin
          // Switch one cycle into the gap so cam_sel never moves on a req edge (needs GAP_CYC >= 2)
          if (switch_cam) begin
            cam_sel_q  <= 1'b1;
            switch_cam <= 1'b0;
          end
        end
        ST_NEXT: begin
          if (tbl_addr != LAST_ADDR) tbl_addr <= tbl_addr + 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  // Request is decoded from state so an async reset removes it immediately
  assign bus.i2c_req   = (state == ST_ISSUE) || (state == ST_BUSY);
  assign bus.i2c_dev   = bus.i2c_req ? DEV_ADDR : 8'h00;
  assign bus.i2c_reg   = lat_reg;
  assign bus.i2c_wdata = lat_data;
  assign bus.cam_sel   = cam_sel_q;

  assign cam_fail       = cam_fail_q;
  assign cmos_init_done = (state == ST_DONE);
  assign cmos1_cfg_ok   = cmos_init_done && !cam_fail_q[0];
  assign cmos2_cfg_ok   = cmos_init_done && !cam_fail_q[1];

endmodule

// File: tb/tb_sccb_cfg_sched.sv
// tb/tb_sccb_cfg_sched.sv - directed self-checking bench for sccb_cfg_sched
module tb_sccb_cfg_sched;

  localparam int TXN_CYC = 3;

  logic        clk_10M = 1'b0;
  logic        rst_n;
  logic        initial_en;
  logic [1:0]  tbl_addr;
  logic [23:0] tbl_data;
  logic        cmos1_cfg_ok;
  logic        cmos2_cfg_ok;
  logic        cmos_init_done;
  logic [1:0]  cam_fail;

  sccb_cfg_sched_if bus ();

  sccb_cfg_sched #(
    .REG_NUM    (4),
    .DEV_ADDR   (8'h78),
    .RETRY_MAX  (3),
    .GAP_CYC    (4),
    .DELAY_UNIT (10)
  ) dut (
    .clk_10M        (clk_10M),
    .rst_n          (rst_n),
    .initial_en     (initial_en),
    .tbl_addr       (tbl_addr),
    .tbl_data       (tbl_data),
    .bus            (bus.master),
    .cmos1_cfg_ok   (cmos1_cfg_ok),
    .cmos2_cfg_ok   (cmos2_cfg_ok),
    .cmos_init_done (cmos_init_done),
    .cam_fail       (cam_fail)
  );

  always #5 clk_10M = ~clk_10M;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Synchronous ROM model
  logic [23:0] rom [0:3];
  always @(posedge clk_10M) tbl_data <= rom[tbl_addr];

  // SCCB master model: fixed latency, scripted NACKs, logs {nack, cam, reg, data}
  bit          cam1_nack_all = 1'b0;
  int          cam0_nack_budget = 0;
  int          nack0_done;
  int          mstate;
  int          mcnt;
  int          dev_bad = 0;
  int          stab_bad = 0;
  logic [24:0] cap;
  logic [25:0] log_q [$];

  function automatic logic decide_nack(input logic sel, input int done0);
    return sel ? logic'(cam1_nack_all) : logic'(cam0_nack_budget > done0);
  endfunction

  always @(posedge clk_10M or negedge rst_n) begin
    if (!rst_n) begin
      mstate       <= 0;
      mcnt         <= 0;
      nack0_done   <= 0;
      bus.i2c_done <= 1'b0;
      bus.i2c_nack <= 1'b0;
    end else begin
      bus.i2c_done <= 1'b0;
      bus.i2c_nack <= 1'b0;
      case (mstate)
        0: if (bus.i2c_req) begin
          mstate <= 1;
          mcnt   <= TXN_CYC;
          cap    <= {bus.cam_sel, bus.i2c_reg, bus.i2c_wdata};
          if (bus.i2c_dev != 8'h78) dev_bad <= dev_bad + 1;
        end
        1: if (mcnt == 1) begin
          bus.i2c_done <= 1'b1;
          bus.i2c_nack <= decide_nack(bus.cam_sel, nack0_done);
          if (!bus.cam_sel && decide_nack(1'b0, nack0_done)) nack0_done <= nack0_done + 1;
          log_q.push_back({decide_nack(bus.cam_sel, nack0_done), bus.cam_sel, bus.i2c_reg, bus.i2c_wdata});
          if ({bus.cam_sel, bus.i2c_reg, bus.i2c_wdata} != cap || !bus.i2c_req) stab_bad <= stab_bad + 1;
          mstate <= 2;
        end else begin
          mcnt <= mcnt - 1;
        end
        default: if (!bus.i2c_req) mstate <= 0;
      endcase
    end
  end

  // cam_sel must not move while a request is up; also time the stay at table index 1
  logic prev_req;
  logic prev_sel;
  int   sel_viol = 0;
  int   dwell1;
  always @(negedge clk_10M) begin
    if (!rst_n) begin
      prev_req <= 1'b0;
      prev_sel <= 1'b0;
      dwell1   <= 0;
    end else begin
      if ((bus.cam_sel !== prev_sel) && (bus.i2c_req || prev_req)) sel_viol <= sel_viol + 1;
      prev_req <= bus.i2c_req;
      prev_sel <= bus.cam_sel;
      if (tbl_addr == 2'd1) dwell1 <= dwell1 + 1;
    end
  end

  function automatic logic [25:0] ent(input logic nk, input logic sel, input logic [23:0] e);
    return {nk, sel, e};
  endfunction

  task automatic do_reset();
    rst_n      = 1'b0;
    initial_en = 1'b0;
    repeat (3) @(negedge clk_10M);
    rst_n = 1'b1;
    @(negedge clk_10M);
  endtask

  task automatic run_to_done(input string tag);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk_10M);
      if (cmos_init_done) break;
    end
    check_val(tag, cmos_init_done, 1);
  endtask

  int base;

  initial begin
    rom[0] = {16'h3103, 8'h11};
    rom[1] = {16'h3017, 8'hFF};
    rom[2] = {16'h3018, 8'hF0};
    rom[3] = {16'h3100, 8'h00};
    rst_n      = 1'b0;
    initial_en = 1'b0;
    repeat (3) @(negedge clk_10M);
    check_val("rst_req", bus.i2c_req, 0);
    check_val("rst_dev", bus.i2c_dev, 0);
    check_val("rst_addr", tbl_addr, 0);
    check_val("rst_outs", {cmos_init_done, cmos1_cfg_ok, cmos2_cfg_ok, cam_fail, bus.cam_sel}, 0);

    // 1: three writable entries plus a zero-data skip, all ACK; initial_en dropped mid-run
    rst_n = 1'b1;
    @(negedge clk_10M);
    base = log_q.size();
    initial_en = 1'b1;
    repeat (6) @(negedge clk_10M);
    initial_en = 1'b0;
    run_to_done("t1_done");
    check_val("t1_count", log_q.size() - base, 6);
    for (int i = 0; i < 6; i++)
      if (base + i < log_q.size())
        check_val($sformatf("t1_w%0d", i), log_q[base + i], ent(1'b0, 1'(i % 2), rom[i / 2]));
    check_val("t1_ok", {cmos1_cfg_ok, cmos2_cfg_ok, cam_fail}, 4'b1100);

    // 2: write then a 2-tick delay entry; index 1 lasts fetch(2)+decode(1)+delay(20)+next(1)
    rom[1] = {16'h3008, 8'h82};
    rom[1] = {16'hFFFF, 8'd2};
    rom[0] = {16'h3008, 8'h82};
    do_reset();
    base = log_q.size();
    initial_en = 1'b1;
    run_to_done("t2_done");
    check_val("t2_count", log_q.size() - base, 4);
    if (log_q.size() >= base + 2) begin
      check_val("t2_w0", log_q[base], ent(1'b0, 1'b0, {16'h3008, 8'h82}));
      check_val("t2_w1", log_q[base + 1], ent(1'b0, 1'b1, {16'h3008, 8'h82}));
    end
    check_val("t2_dwell", dwell1, 24);

    // 3: cam1 always NACKs -> four attempts on entry 0, then cam0 only
    rom[0] = {16'h3103, 8'h11};
    rom[1] = {16'h3017, 8'hFF};
    cam1_nack_all = 1'b1;
    do_reset();
    base = log_q.size();
    initial_en = 1'b1;
    run_to_done("t3_done");
    check_val("t3_count", log_q.size() - base, 7);
    if (log_q.size() >= base + 7) begin
      for (int i = 1; i < 5; i++)
        check_val($sformatf("t3_cam1_try%0d", i), log_q[base + i], ent(1'b1, 1'b1, rom[0]));
      check_val("t3_w5", log_q[base + 5], ent(1'b0, 1'b0, rom[1]));
      check_val("t3_w6", log_q[base + 6], ent(1'b0, 1'b0, rom[2]));
    end
    check_val("t3_ok", {cmos1_cfg_ok, cmos2_cfg_ok, cam_fail}, 4'b1010);

    // 4: cam0 NACKs once -> single retry, nothing duplicated afterwards
    cam1_nack_all    = 1'b0;
    cam0_nack_budget = 1;
    do_reset();
    base = log_q.size();
    initial_en = 1'b1;
    run_to_done("t4_done");
    check_val("t4_count", log_q.size() - base, 7);
    if (log_q.size() >= base + 7) begin
      check_val("t4_w0", log_q[base], ent(1'b1, 1'b0, rom[0]));
      check_val("t4_w1", log_q[base + 1], ent(1'b0, 1'b0, rom[0]));
      check_val("t4_w2", log_q[base + 2], ent(1'b0, 1'b1, rom[0]));
      for (int i = 3; i < 7; i++)
        check_val($sformatf("t4_w%0d", i), log_q[base + i], ent(1'b0, 1'((i - 1) % 2), rom[(i - 1) / 2]));
    end
    check_val("t4_ok", {cmos1_cfg_ok, cmos2_cfg_ok, cam_fail}, 4'b1100);

    // 5: reset while a request is up, then restart from index 0
    cam0_nack_budget = 0;
    do_reset();
    initial_en = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk_10M);
      if (bus.i2c_req) break;
    end
    check_val("t5_req_seen", bus.i2c_req, 1);
    #2 rst_n = 1'b0;
    #1;
    check_val("t5_req_drop", bus.i2c_req, 0);
    check_val("t5_addr_rst", tbl_addr, 0);
    repeat (2) @(negedge clk_10M);
    base = log_q.size();
    rst_n = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk_10M);
      if (bus.i2c_req) break;
    end
    check_val("t5_restart", {tbl_addr, bus.i2c_reg, bus.i2c_req}, {2'd0, 16'h3103, 1'b1});
    run_to_done("t5_done");
    check_val("t5_count", log_q.size() - base, 6);

    // 6: bus-wide invariants across all runs
    check_val("sel_stable", sel_viol, 0);
    check_val("dev_addr", dev_bad, 0);
    check_val("fields_stable", stab_bad, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
